// File: rtl/dis_scroll_layer_pkg.sv
// Shared types, colours and bitmap/palette contents for the scrolling background layer.
package dis_scroll_layer_pkg;

    localparam logic [15:0] C_SKY    = 16'h7E39;
    localparam logic [15:0] C_TREE   = 16'h8F31;
    localparam logic [15:0] C_GROUND = 16'hDED2;

    localparam string IMG_FILE_DEFAULT = "images/background.mem";
    localparam string PAL_FILE_DEFAULT = "images/background_palette.mem";

    // Fill band selected for a pixel; the first matching band wins.
    typedef enum logic [1:0] {
        BAND_NONE,
        BAND_GROUND,
        BAND_TREE,
        BAND_SKY
    } band_t;

    // Control fields that travel alongside the pixel data through the pipeline.
    typedef struct packed {
        logic  valid;
        logic  in_spr;
        band_t band;
    } ctl_t;

    function automatic logic [15:0] rgb565(input int r, input int g, input int b);
        return {5'(r), 6'(g), 5'(b)};
    endfunction

    // Background bitmap: palette index per texel, with scattered transparent texels.
    function automatic logic [3:0] img_texel(input int a);
        int t;
        t = (a * 73) ^ (a >> 3) ^ (a >> 7);
        if (t % 13 == 12) return 4'd15;
        return 4'(t % 9);
    endfunction

    // Background palette, RGB565.
    function automatic logic [15:0] pal_entry(input int i);
        return rgb565(i * 3, i * 7 + 1, 31 - i);
    endfunction

endpackage

// File: rtl/dis_scroll_ctr.sv
// Per-frame scroll offset register, wrapping in [0, P).
module dis_scroll_ctr #(
    parameter int P     = 480,
    parameter int OFF_W = $clog2(P)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             frame_tick,
    input  logic             scroll_en,
    input  logic [3:0]       scroll_speed,
    input  logic             scroll_rst,
    output logic [OFF_W-1:0] off
);

    logic [OFF_W:0] sum;

    // Candidate advanced offset before wrap.
    always_comb begin
        sum = {1'b0, off} + (OFF_W+1)'(scroll_speed);
    end

    // Clear has priority over advance; speed is below P so one subtraction wraps.
    always_ff @(posedge clk) begin
        if (!rstn || scroll_rst) begin
            off <= '0;
        end else if (frame_tick && scroll_en) begin
            if (sum >= (OFF_W+1)'(P)) off <= OFF_W'(sum - (OFF_W+1)'(P));
            else                      off <= sum[OFF_W-1:0];
        end
    end

endmodule

// File: rtl/rom.sv
// Constant ROM with one-cycle registered read; out-of-range addresses read as 0.
module rom
    import dis_scroll_layer_pkg::*;
#(
    parameter int    WIDTH     = 16,
    parameter int    DEPTH     = 9,
    parameter string INIT_FILE = ""
) (
    input  logic                     clk,
    input  logic [$clog2(DEPTH)-1:0] addr,
    output logic [WIDTH-1:0]         data
);

    localparam bit IS_PAL = (INIT_FILE == PAL_FILE_DEFAULT);

    logic [WIDTH-1:0] mem [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_init
            if (IS_PAL) begin : g_pal
                assign mem[gi] = WIDTH'(pal_entry(gi));
            end else begin : g_img
                assign mem[gi] = WIDTH'(img_texel(gi));
            end
        end
    endgenerate

    // Registered read port.
    always_ff @(posedge clk) begin
        data <= (int'(addr) < DEPTH) ? mem[addr] : '0;
    end

endmodule

// File: rtl/dis_scroll_layer.sv
// Horizontally scrolling, paletted background layer with fixed 5-cycle latency.
module dis_scroll_layer
    import dis_scroll_layer_pkg::*;
#(
    parameter int    POS_X       = 192,
    parameter int    SPR_H       = 40,
    parameter int    SPR_W       = 120,
    parameter int    SCALE_SHIFT = 2,
    parameter int    IDX_W       = 4,
    parameter int    PAL_DEPTH   = 9,
    parameter int    TRANSP_IDX  = 15,
    parameter int    LOOKAHEAD   = 5,
    parameter string IMG_FILE    = IMG_FILE_DEFAULT,
    parameter string PAL_FILE    = PAL_FILE_DEFAULT,
    parameter int    BAND0_END   = 160,
    parameter int    BAND1_END   = 192,
    parameter int    BAND2_BEG   = 352
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [15:0] paint_x,
    input  logic [15:0] paint_y,
    input  logic        frame_tick,
    input  logic        scroll_en,
    input  logic [3:0]  scroll_speed,
    input  logic        scroll_rst,
    output logic [15:0] paint_color,
    output logic        paint_enable
);

    localparam int P      = SPR_W << SCALE_SHIFT;
    localparam int OFF_W  = $clog2(P);
    localparam int STRIP  = SPR_H << SCALE_SHIFT;
    localparam int ADDR_W = $clog2(SPR_H * SPR_W);
    localparam int PAL_AW = $clog2(PAL_DEPTH);

    localparam logic signed [17:0] P_S     = 18'(P);
    localparam logic signed [17:0] STRIP_S = 18'(STRIP);
    localparam logic signed [17:0] B0_S    = 18'(BAND0_END);
    localparam logic signed [17:0] B1_S    = 18'(BAND1_END);
    localparam logic signed [17:0] B2_S    = 18'(BAND2_BEG);

    logic [OFF_W-1:0]   off;
    logic signed [17:0] xl, sx, ys, sy_next;
    ctl_t               ctl_next;
    ctl_t               ctl_reg [4];
    logic signed [17:0] sx_reg, sy_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic [IDX_W-1:0]   idx, idx4_reg;
    logic [PAL_AW-1:0]  pal_addr;
    logic [15:0]        pal_color;
    logic [15:0]        fill_color;
    logic               fill_en;
    logic [15:0]        color_reg;
    logic               enable_reg;

    dis_scroll_ctr #(.P(P), .OFF_W(OFF_W)) u_ctr (
        .clk          (clk),
        .rstn         (rstn),
        .frame_tick   (frame_tick),
        .scroll_en    (scroll_en),
        .scroll_speed (scroll_speed),
        .scroll_rst   (scroll_rst),
        .off          (off)
    );

    // Stage 1 combinational: strip-relative x, wrapped y, strip membership and band.
    always_comb begin
        xl = 18'(signed'(paint_x)) + 18'(LOOKAHEAD);
        sx = xl - 18'(POS_X);
        ys = 18'(signed'(paint_y)) + signed'(18'(off));
        if (ys < 0)          sy_next = ys + P_S;
        else if (ys >= P_S)  sy_next = ys - P_S;
        else                 sy_next = ys;
        ctl_next.valid  = 1'b1;
        ctl_next.in_spr = (sx >= 0) && (sx < STRIP_S);
        if (xl >= 0 && xl < B0_S)          ctl_next.band = BAND_GROUND;
        else if (xl >= B0_S && xl < B1_S)  ctl_next.band = BAND_TREE;
        else if (xl >= B2_S)               ctl_next.band = BAND_SKY;
        else                               ctl_next.band = BAND_NONE;
    end

    // Control pipeline: stages 1..4, flushed by reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < 4; i++) ctl_reg[i] <= '0;
        end else begin
            ctl_reg[0] <= ctl_next;
            for (int i = 1; i < 4; i++) ctl_reg[i] <= ctl_reg[i-1];
        end
    end

    // Stage 1 and 2 data: coordinates, then texel address.
    always_ff @(posedge clk) begin
        sx_reg   <= sx;
        sy_reg   <= sy_next;
        addr_reg <= ADDR_W'(sx_reg >>> SCALE_SHIFT)
                  + ADDR_W'(sy_reg >>> SCALE_SHIFT) * ADDR_W'(SPR_H);
    end

    // Stage 3: index ROM.
    rom #(.WIDTH(IDX_W), .DEPTH(SPR_H * SPR_W), .INIT_FILE(IMG_FILE)) u_img (
        .clk  (clk),
        .addr (addr_reg),
        .data (idx)
    );

    assign pal_addr = PAL_AW'(idx);

    // Stage 4: palette ROM, with the index carried along for the transparency test.
    rom #(.WIDTH(16), .DEPTH(PAL_DEPTH), .INIT_FILE(PAL_FILE)) u_pal (
        .clk  (clk),
        .addr (pal_addr),
        .data (pal_color)
    );

    // Carry the index alongside the palette read.
    always_ff @(posedge clk) begin
        idx4_reg <= idx;
    end

    // Fill colour of the band aligned with the stage-4 pixel.
    always_comb begin
        fill_color = 16'h0000;
        fill_en    = 1'b1;
        case (ctl_reg[3].band)
            BAND_GROUND: fill_color = C_GROUND;
            BAND_TREE:   fill_color = C_TREE;
            BAND_SKY:    fill_color = C_SKY;
            default:     fill_en    = 1'b0;
        endcase
    end

    // Stage 5: output select between bitmap and fill bands.
    always_ff @(posedge clk) begin
        if (!rstn || !ctl_reg[3].valid) begin
            color_reg  <= 16'h0000;
            enable_reg <= 1'b0;
        end else if (ctl_reg[3].in_spr && idx4_reg != IDX_W'(TRANSP_IDX)) begin
            color_reg  <= pal_color;
            enable_reg <= 1'b1;
        end else begin
            color_reg  <= fill_color;
            enable_reg <= fill_en;
        end
    end

    assign paint_color  = color_reg;
    assign paint_enable = enable_reg;

endmodule

// File: tb/tb_dis_scroll_layer.sv
// Bench for dis_scroll_layer: directed scenarios plus a random stream against a pixel model.
module tb_dis_scroll_layer;

    localparam int P        = 480;
    localparam int NC       = 4096;
    localparam int GROUND   = 16'hDED2;
    localparam int TREE     = 16'h8F31;
    localparam int SKY      = 16'h7E39;

    logic        clk;
    logic        rstn;
    logic [15:0] paint_x, paint_y;
    logic        frame_tick, scroll_en, scroll_rst;
    logic [3:0]  scroll_speed;
    logic [15:0] paint_color;
    logic        paint_enable;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int off_m    = 0;

    logic [15:0] obs_col [NC];
    logic        obs_en  [NC];
    logic [15:0] exp_col [NC];
    logic        exp_en  [NC];

    dis_scroll_layer dut (
        .clk          (clk),
        .rstn         (rstn),
        .paint_x      (paint_x),
        .paint_y      (paint_y),
        .frame_tick   (frame_tick),
        .scroll_en    (scroll_en),
        .scroll_speed (scroll_speed),
        .scroll_rst   (scroll_rst),
        .paint_color  (paint_color),
        .paint_enable (paint_enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bitmap and palette contents of the background image.
    function automatic int img(input int a);
        int t;
        t = (a * 73) ^ (a >> 3) ^ (a >> 7);
        if (t % 13 == 12) return 15;
        return t % 9;
    endfunction

    function automatic int pal(input int i);
        return ((i * 3) << 11) | ((i * 7 + 1) << 5) | (31 - i);
    endfunction

    // Pixel rule: {enable, colour} for screen (x, y) at scroll offset off.
    function automatic logic [16:0] model(input int x, input int y, input int off);
        int xl, sx, s, id;
        xl = x + 5;
        sx = xl - 192;
        if (sx >= 0 && sx < 160) begin
            s = y + off;
            if (s < 0) s += P;
            else if (s >= P) s -= P;
            id = img(sx / 4 + (s / 4) * 40);
            if (id != 15) return {1'b1, 16'(pal(id))};
        end
        if (xl >= 0 && xl < 160)   return {1'b1, 16'(GROUND)};
        if (xl >= 160 && xl < 192) return {1'b1, 16'(TREE)};
        if (xl >= 352)             return {1'b1, 16'(SKY)};
        return 17'h0;
    endfunction

    // One request cycle: sample outputs, apply inputs, record the expected result.
    task automatic drive(input int x, input int y, input bit tick, input bit en,
                         input int spd, input bit srst, input bit rn);
        @(negedge clk);
        obs_col[cyc] = paint_color;
        obs_en[cyc]  = paint_enable;
        rstn         = rn;
        paint_x      = 16'(x);
        paint_y      = 16'(y);
        frame_tick   = tick;
        scroll_en    = en;
        scroll_speed = 4'(spd);
        scroll_rst   = srst;
        if (!rn) begin
            for (int k = cyc - 4; k <= cyc; k++)
                if (k >= 0) begin exp_col[k] = 16'h0; exp_en[k] = 1'b0; end
            off_m = 0;
        end else begin
            {exp_en[cyc], exp_col[cyc]} = model(x, y, off_m);
            if (srst) off_m = 0;
            else if (tick && en) begin
                off_m += spd;
                if (off_m >= P) off_m -= P;
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(-20, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        int r;
        for (int i = 0; i < 3; i++) drive(187, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        r = cyc;
        for (int i = 0; i < 6; i++) drive(187 + 4 * i, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        idle(6);
        for (int k = 1; k < r + 5; k++) begin
            n_checks++;
            if (obs_col[k] !== 16'h0 || obs_en[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_zero cycle %0d: got en=%b col=%h, want en=0 col=0000",
                         k, obs_en[k], obs_col[k]);
            end
        end
        n_checks++;
        if (obs_col[r+5] !== 16'(pal(img(0))) || obs_en[r+5] !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first_pixel: got en=%b col=%h, want en=1 col=%h",
                     obs_en[r+5], obs_col[r+5], 16'(pal(img(0))));
        end
    endtask

    task automatic test_align();
        int k;
        k = cyc;
        drive(187, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        drive(347, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        drive(190, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        drive(191, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        drive(346, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        idle(6);
        n_checks++;
        if (obs_col[k+5] !== 16'h003F || obs_en[k+5] !== 1'b1) begin
            n_fail++;
            $display("FAIL align_sx0: got en=%b col=%h, want en=1 col=003f", obs_en[k+5], obs_col[k+5]);
        end
        n_checks++;
        if (obs_col[k+6] !== 16'(SKY) || obs_en[k+6] !== 1'b1) begin
            n_fail++;
            $display("FAIL align_sx160: got en=%b col=%h, want en=1 col=%h", obs_en[k+6], obs_col[k+6], 16'(SKY));
        end
        for (int j = 2; j < 5; j++) begin
            n_checks++;
            if (obs_col[k+j+5] !== exp_col[k+j] || obs_en[k+j+5] !== exp_en[k+j]) begin
                n_fail++;
                $display("FAIL align_px%0d: got en=%b col=%h, want en=%b col=%h",
                         j, obs_en[k+j+5], obs_col[k+j+5], exp_en[k+j], exp_col[k+j]);
            end
        end
    endtask

    task automatic test_fill();
        int xs [8] = '{100, 170, -20, 154, 155, 186, 0, -6};
        int want_col [8] = '{GROUND, TREE, 0, GROUND, TREE, TREE, GROUND, 0};
        bit want_en [8]  = '{1, 1, 0, 1, 1, 1, 1, 0};
        int k;
        k = cyc;
        for (int i = 0; i < 8; i++) drive(xs[i], 7, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        idle(6);
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (obs_col[k+i+5] !== 16'(want_col[i]) || obs_en[k+i+5] !== want_en[i]) begin
                n_fail++;
                $display("FAIL fill_x%0d: got en=%b col=%h, want en=%b col=%h",
                         xs[i], obs_en[k+i+5], obs_col[k+i+5], want_en[i], 16'(want_col[i]));
            end
        end
    endtask

    task automatic test_scroll_wrap();
        int ys [4] = '{0, 477, 479, -3};
        int k;
        drive(-20, 0, 1'b0, 1'b0, 0, 1'b1, 1'b1);
        for (int i = 0; i < 69; i++) drive(-20, 0, 1'b1, 1'b1, 7, 1'b0, 1'b1);
        k = cyc;
        for (int i = 0; i < 4; i++) drive(187, ys[i], 1'b0, 1'b0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) drive(187 + 20 * i, 1 + 4 * i, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        idle(6);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (obs_col[k+i+5] !== 16'h003F || obs_en[k+i+5] !== 1'b1) begin
                n_fail++;
                $display("FAIL wrap_y%0d: got en=%b col=%h, want en=1 col=003f",
                         ys[i], obs_en[k+i+5], obs_col[k+i+5]);
            end
        end
        for (int i = 4; i < 12; i++) begin
            n_checks++;
            if (obs_col[k+i+5] !== exp_col[k+i] || obs_en[k+i+5] !== exp_en[k+i]) begin
                n_fail++;
                $display("FAIL wrap_row px%0d: got en=%b col=%h, want en=%b col=%h",
                         i, obs_en[k+i+5], obs_col[k+i+5], exp_en[k+i], exp_col[k+i]);
            end
        end
    endtask

    task automatic test_priority();
        int k;
        k = cyc;
        drive(-20, 0, 1'b1, 1'b1, 15, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) drive(187 + 16 * i, 8 + 8 * i, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) drive(-20, 0, 1'b1, 1'b1, 11, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) drive(-20, 0, 1'b1, 1'b0, 9, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) drive(195 + 16 * i, 12 + 8 * i, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        idle(6);
        for (int i = k; i < cyc - 6; i++) begin
            n_checks++;
            if (obs_col[i+5] !== exp_col[i] || obs_en[i+5] !== exp_en[i]) begin
                n_fail++;
                $display("FAIL priority req %0d: got en=%b col=%h, want en=%b col=%h",
                         i - k, obs_en[i+5], obs_col[i+5], exp_en[i], exp_col[i]);
            end
        end
    endtask

    task automatic test_transparency();
        int a, k;
        a = -1;
        for (int t = 0; t < 4800 && a < 0; t++) if (img(t) == 15) a = t;
        n_checks++;
        if (a < 0) begin
            n_fail++;
            $display("FAIL transp_search: got no transparent texel, want one");
        end else begin
            drive(-20, 0, 1'b0, 1'b0, 0, 1'b1, 1'b1);
            k = cyc;
            drive(187 + (a % 40) * 4, (a / 40) * 4, 1'b0, 1'b0, 0, 1'b0, 1'b1);
            drive(190 + (a % 40) * 4, (a / 40) * 4 + 3, 1'b0, 1'b0, 0, 1'b0, 1'b1);
            idle(6);
            for (int j = 0; j < 2; j++) begin
                n_checks++;
                if (obs_col[k+j+5] !== 16'h0 || obs_en[k+j+5] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL transp texel %0d px%0d: got en=%b col=%h, want en=0 col=0000",
                             a, j, obs_en[k+j+5], obs_col[k+j+5]);
                end
            end
        end
    endtask

    task automatic test_midframe_reset();
        int k;
        k = cyc;
        for (int i = 0; i < 8; i++) drive(187 + 8 * i, 4 * i, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        drive(187, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive(100 + 30 * i, 4 * i, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        idle(6);
        for (int i = k; i < cyc - 6; i++) begin
            n_checks++;
            if (obs_col[i+5] !== exp_col[i] || obs_en[i+5] !== exp_en[i]) begin
                n_fail++;
                $display("FAIL midreset req %0d: got en=%b col=%h, want en=%b col=%h",
                         i - k, obs_en[i+5], obs_col[i+5], exp_en[i], exp_col[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int k;
        k = cyc;
        for (int i = 0; i < 400; i++) begin
            drive(int'($urandom_range(480)) - 60, int'($urandom_range(959)) - 480,
                  ($urandom_range(7) == 0), ($urandom_range(3) != 0),
                  int'($urandom_range(15)), ($urandom_range(49) == 0), 1'b1);
        end
        idle(6);
        for (int i = k; i < k + 400; i++) begin
            n_checks++;
            if (obs_col[i+5] !== exp_col[i] || obs_en[i+5] !== exp_en[i]) begin
                n_fail++;
                $display("FAIL stream req %0d: got en=%b col=%h, want en=%b col=%h",
                         i - k, obs_en[i+5], obs_col[i+5], exp_en[i], exp_col[i]);
            end
        end
    endtask

    initial begin
        rstn         = 1'b0;
        paint_x      = 16'h0;
        paint_y      = 16'h0;
        frame_tick   = 1'b0;
        scroll_en    = 1'b0;
        scroll_speed = 4'h0;
        scroll_rst   = 1'b0;
        test_reset();
        test_align();
        test_fill();
        test_scroll_wrap();
        test_priority();
        test_transparency();
        test_midframe_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
